// File: rtl/div_meter_pkg.sv
// Shared types and constants for the divided-clock period meter (and the divider
// that shares its counter width).
package div_meter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_e;

  localparam int DIV_CNT_W = 20;

  // Last count value that can still be followed by cnt+1 without wrapping.
  function automatic longint unsigned timeout_thresh(input int unsigned cnt_w);
    return (64'd1 << cnt_w) - 64'd2;
  endfunction

endpackage

// File: rtl/div_sig_sync_edge.sv
// Multi-flop synchroniser for an asynchronous slow signal plus a rising-edge
// detector on the synchronised copy.
module div_sig_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic sig_in,
  output logic sig_s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_d_q;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q  <= '0;
      sig_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sig_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sig_s = sync_q[SYNC_STAGES-1];
  assign rise  = sig_s & ~sig_d_q;

endmodule

// File: rtl/div_clk_period_meter.sv
// Measures the period of a slow square wave in clk_in cycles between rising edges.
// Define DIV_PERIOD_DUTY_MEASURE_EN to add the high-time output high_out.
//
// state   | meaning
// IDLE    | not measuring; waiting for en=1 and a rising edge to start
// MEASURE | counting cycles since the last rising edge; strobes on each new edge
module div_clk_period_meter
  import div_meter_pkg::*;
#(
  parameter int CNT_W       = DIV_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             overflow,
`ifdef DIV_PERIOD_DUTY_MEASURE_EN
  output logic [CNT_W-1:0] high_out,
`endif
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(timeout_thresh(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  meter_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  logic sig_s, rise;
  logic meas_active, strobe, timeout;

  div_sig_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk_in (clk_in),
    .rst    (rst),
    .sig_in (sig_in),
    .sig_s  (sig_s),
    .rise   (rise)
  );

  assign meas_active = en && (state_q == MEASURE);
  assign strobe      = meas_active && rise;
  // A rise on the threshold cycle still completes the period, so rise wins.
  assign timeout     = meas_active && !rise && (cnt_q == CNT_TIMEOUT);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    period_d = period_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) state_d = MEASURE;
        end
        MEASURE: begin
          if (strobe) begin
            period_d = cnt_q + CNT_ONE;
            valid_d  = 1'b1;
            ovf_d    = 1'b0;
          end else if (timeout) begin
            ovf_d   = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef DIV_PERIOD_DUTY_MEASURE_EN
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] high_q, high_d;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      hcnt_q <= '0;
      high_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      high_q <= high_d;
    end
  end

  // The rise cycle itself is high, so it is added when the result is latched.
  always_comb begin
    hcnt_d = '0;
    high_d = high_q;
    if (strobe) begin
      high_d = hcnt_q + CNT_ONE;
    end else if (meas_active && !timeout) begin
      hcnt_d = sig_s ? hcnt_q + CNT_ONE : hcnt_q;
    end
  end

  assign high_out = high_q;
`else
  logic unused_sig_s;
  assign unused_sig_s = sig_s;
`endif

  assign period_out   = period_q;
  assign period_valid = valid_q;
  assign overflow     = ovf_q;
  assign busy         = (state_q == MEASURE);

endmodule

// File: tb/tb_div_clk_period_meter.sv
// Directed bench for div_clk_period_meter: an 8-bit instance for normal periods
// and a 4-bit instance for timeout and threshold corners, sharing all inputs.
module tb_div_clk_period_meter;

  logic clk_in = 1'b0;
  logic rst, en, sig_in;

  logic [7:0] period_a;
  logic       pv_a, ovf_a, busy_a;
  logic [3:0] period_b;
  logic       pv_b, ovf_b, busy_b;
`ifdef DIV_PERIOD_DUTY_MEASURE_EN
  logic [7:0] high_a;
  logic [3:0] high_b;
`endif

  always #5 clk_in = ~clk_in;

  div_clk_period_meter #(.CNT_W(8), .SYNC_STAGES(2)) dut_a (
    .clk_in       (clk_in),
    .rst          (rst),
    .en           (en),
    .sig_in       (sig_in),
    .period_out   (period_a),
    .period_valid (pv_a),
    .overflow     (ovf_a),
`ifdef DIV_PERIOD_DUTY_MEASURE_EN
    .high_out     (high_a),
`endif
    .busy         (busy_a)
  );

  div_clk_period_meter #(.CNT_W(4), .SYNC_STAGES(3)) dut_b (
    .clk_in       (clk_in),
    .rst          (rst),
    .en           (en),
    .sig_in       (sig_in),
    .period_out   (period_b),
    .period_valid (pv_b),
    .overflow     (ovf_b),
`ifdef DIV_PERIOD_DUTY_MEASURE_EN
    .high_out     (high_b),
`endif
    .busy         (busy_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_str_a, first_t_a, prev_t_a, last_t_a, last_p_a, last_h_a;
  int n_str_b, last_p_b;

  typedef struct {
    int hi;
    int lo;
    int n;
    int exp_p;
    int exp_h;
    int exp_lat;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
    if (pv_a) begin
      n_str_a++;
      if (n_str_a == 1) first_t_a = cyc;
      prev_t_a = last_t_a;
      last_t_a = cyc;
      last_p_a = int'(period_a);
`ifdef DIV_PERIOD_DUTY_MEASURE_EN
      last_h_a = int'(high_a);
`endif
    end
    if (pv_b) begin
      n_str_b++;
      last_p_b = int'(period_b);
    end
  endtask

  task automatic clear_stats();
    n_str_a = 0; first_t_a = 0; prev_t_a = 0; last_t_a = 0; last_p_a = 0; last_h_a = 0;
    n_str_b = 0; last_p_b = 0;
  endtask

  task automatic do_reset();
    sig_in = 1'b0;
    en     = 1'b1;
    rst    = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_stats();
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      sig_in = 1'b1;
      repeat (hi) tick();
      sig_in = 1'b0;
      repeat (lo) tick();
    end
  endtask

  initial begin
    int start, w, nb, last_ovf, held_bad;

    //        hi  lo  n  period high first-strobe latency (period + 3)
    vecs[0] = '{3,  3,  4, 6,  3,  9};
    vecs[1] = '{12, 12, 4, 24, 12, 27};
    vecs[2] = '{5,  5,  4, 10, 5,  13};
    vecs[3] = '{1,  7,  4, 8,  1,  11};

    rst = 1'b1; en = 1'b0; sig_in = 1'b0;
    clear_stats();
    tick();
    tick();
    chk("rst_period_a", int'(period_a), 0);
    chk("rst_valid_a", int'(pv_a), 0);
    chk("rst_ovf_a", int'(ovf_a), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_period_b", int'(period_b), 0);
    chk("rst_ovf_b", int'(ovf_b), 0);
    chk("rst_busy_b", int'(busy_b), 0);
`ifdef DIV_PERIOD_DUTY_MEASURE_EN
    chk("rst_high_a", int'(high_a), 0);
`endif

    // Table: square waves on the 8-bit instance
    for (int i = 0; i < 4; i++) begin
      do_reset();
      repeat (3) tick();
      start = cyc;
      wave(vecs[i].hi, vecs[i].lo, vecs[i].n);
      chk($sformatf("tbl%0d_strobes", i), n_str_a, vecs[i].n - 1);
      chk($sformatf("tbl%0d_period", i), last_p_a, vecs[i].exp_p);
      chk($sformatf("tbl%0d_first_lat", i), first_t_a - start, vecs[i].exp_lat);
      chk($sformatf("tbl%0d_spacing", i), last_t_a - prev_t_a, vecs[i].exp_p);
      chk($sformatf("tbl%0d_ovf", i), int'(ovf_a), 0);
      chk($sformatf("tbl%0d_busy", i), int'(busy_a), 1);
`ifdef DIV_PERIOD_DUTY_MEASURE_EN
      chk($sformatf("tbl%0d_high", i), last_h_a, vecs[i].exp_h);
`endif
    end

    // Constant level after one rise: no strobe, eventual timeout on the 8-bit instance
    do_reset();
    sig_in = 1'b1;
    repeat (300) tick();
    chk("const_strobes", n_str_a, 0);
    chk("const_ovf", int'(ovf_a), 1);
    chk("const_busy", int'(busy_a), 0);

    // 4-bit timeout: busy for cnt 0..14 then overflow, no strobe
    do_reset();
    sig_in = 1'b1;
    w = 0;
    while (!busy_b && w < 10) begin
      tick();
      w++;
    end
    chk("to_busy_seen", int'(busy_b), 1);
    sig_in = 1'b0;
    nb = 0;
    last_ovf = -1;
    while (busy_b && nb < 40) begin
      nb++;
      last_ovf = int'(ovf_b);
      tick();
    end
    chk("to_busy_cycles", nb, 15);
    chk("to_ovf_before", last_ovf, 0);
    chk("to_ovf", int'(ovf_b), 1);
    chk("to_strobes", n_str_b, 0);
    wave(2, 3, 3);
    chk("to_recover_strobes", n_str_b, 2);
    chk("to_recover_period", last_p_b, 5);
    chk("to_recover_ovf", int'(ovf_b), 0);

    // Period 15 on 4 bits: rise lands on the threshold and wins
    do_reset();
    wave(7, 8, 3);
    chk("p15_strobes", n_str_b, 2);
    chk("p15_period", last_p_b, 15);
    chk("p15_ovf", int'(ovf_b), 0);
    chk("p15_busy", int'(busy_b), 1);

    // Period 16 on 4 bits: always times out
    do_reset();
    wave(8, 8, 3);
    chk("p16_strobes", n_str_b, 0);
    chk("p16_ovf", int'(ovf_b), 1);

    // en dropped mid-period
    do_reset();
    wave(3, 3, 3);
    chk("en_pre_period", last_p_a, 6);
    sig_in = 1'b1;
    repeat (5) tick();
    sig_in = 1'b0;
    repeat (2) tick();
    en = 1'b0;
    held_bad = 0;
    repeat (3) begin
      tick();
      if (period_a != 8'd6) held_bad++;
    end
    chk("en_low_held", held_bad, 0);
    chk("en_low_busy", int'(busy_a), 0);
    clear_stats();
    en = 1'b1;
    repeat (2) tick();
    chk("en_reen_held", int'(period_a), 6);
    start = cyc;
    wave(5, 5, 3);
    chk("en_strobes", n_str_a, 2);
    chk("en_first_lat", first_t_a - start, 13);
    chk("en_period", last_p_a, 10);

    // rst mid-measurement
    do_reset();
    wave(3, 3, 2);
    chk("rst_pre_period", last_p_a, 6);
    sig_in = 1'b1;
    repeat (3) tick();
    chk("rst_pre_busy", int'(busy_a), 1);
    clear_stats();
    rst = 1'b1;
    sig_in = 1'b0;
    tick();
    chk("rstmid_period", int'(period_a), 0);
    chk("rstmid_valid", int'(pv_a), 0);
    chk("rstmid_busy", int'(busy_a), 0);
    chk("rstmid_ovf", int'(ovf_a), 0);
    rst = 1'b0;
    repeat (4) tick();
    start = cyc;
    wave(4, 4, 3);
    chk("rstmid_strobes", n_str_a, 2);
    chk("rstmid_first_lat", first_t_a - start, 11);
    chk("rstmid_new_period", last_p_a, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
